// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back controller.
package regfile_wb_pkg;

    localparam int RF_ADDR_W = 3;
    localparam int RF_DATA_W = 32;

    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_ID  = 1'b1;

    // One queued register-file write: which source produced it, where it goes, what it writes.
    typedef struct packed {
        logic                 sel;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Bundle of the write-back controller's producer handshakes, register-file
// write port and bypass lookup. The slave view belongs to the controller,
// the master view to whatever surrounds it (pipeline stages, register file).
interface regfile_wb_ctrl_if;
    import regfile_wb_pkg::*;

    logic                 alu_valid;
    logic [RF_ADDR_W-1:0] alu_addr;
    logic [RF_DATA_W-1:0] alu_data;
    logic                 alu_ready;

    logic                 id_valid;
    logic [RF_ADDR_W-1:0] id_addr;
    logic [RF_DATA_W-1:0] id_data;
    logic                 id_ready;

    logic [RF_ADDR_W-1:0] w_addr;
    logic                 w_enable;
    logic                 w_select;
    logic [RF_DATA_W-1:0] w_alu;
    logic [RF_DATA_W-1:0] w_id;

    logic [RF_ADDR_W-1:0] rd_addr_0;
    logic [RF_ADDR_W-1:0] rd_addr_1;
    logic                 byp_hit_0;
    logic                 byp_hit_1;
    logic [RF_DATA_W-1:0] byp_data_0;
    logic [RF_DATA_W-1:0] byp_data_1;

    modport master (
        output alu_valid, alu_addr, alu_data, id_valid, id_addr, id_data,
               rd_addr_0, rd_addr_1,
        input  alu_ready, id_ready, w_addr, w_enable, w_select, w_alu, w_id,
               byp_hit_0, byp_hit_1, byp_data_0, byp_data_1
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, id_valid, id_addr, id_data,
               rd_addr_0, rd_addr_1,
        output alu_ready, id_ready, w_addr, w_enable, w_select, w_alu, w_id,
               byp_hit_0, byp_hit_1, byp_data_0, byp_data_1
    );

endinterface

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
// Dual-push, single-pop circular buffer of pending register-file writes.
// Push slot 0 is always older than push slot 1; a lone push1 lands at the tail.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push0,
    input  wb_entry_t                entry0,
    input  logic                     push1,
    input  wb_entry_t                entry1,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH)-1:0] head_ptr,
    output wb_entry_t [DEPTH-1:0]    entries
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      tail_ptr;
    logic [PTR_W-1:0]      wr1_ptr;

    // The second push follows the first only when the first actually happened.
    assign wr1_ptr  = tail_ptr + PTR_W'(push0);
    assign head     = mem[head_ptr];
    assign entries  = mem;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap for free.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + PTR_W'(pop);
            tail_ptr <= tail_ptr + PTR_W'(push0) + PTR_W'(push1);
            count    <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    // Entry storage; slots are only meaningful while covered by count.
    // NOTE: the storage array has no reset; occupancy gates every read, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (push0) mem[tail_ptr] <= entry0;
        if (push1) mem[wr1_ptr]  <= entry1;
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller feeding the single write port of the 8x32 register file.
// Results from the ALU and ID stages are queued in program order (ALU older)
// and retired one per cycle from the queue head.
// Optional feature: define RF_WB_BYPASS_EN to enable the bypass lookup of
// queued-but-uncommitted values; otherwise byp_hit_k / byp_data_k are tied to 0.
module regfile_wb_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_wb_ctrl_if.slave   bus
);
    import regfile_wb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ROOM1 = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ROOM2 = CNT_W'(DEPTH - 2);

    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      head_ptr;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    wb_entry_t             alu_entry;
    wb_entry_t             id_entry;
    logic                  alu_acc;
    logic                  id_acc;
    logic                  pop;

    // Readiness looks only at the registered count, never at this cycle's pop.
    assign bus.alu_ready = (count <= CNT_ROOM1);
    assign bus.id_ready  = bus.alu_valid ? (count <= CNT_ROOM2) : (count <= CNT_ROOM1);

    assign alu_acc   = bus.alu_valid & bus.alu_ready;
    assign id_acc    = bus.id_valid  & bus.id_ready;
    assign alu_entry = '{sel: SEL_ALU, addr: bus.alu_addr, data: bus.alu_data};
    assign id_entry  = '{sel: SEL_ID,  addr: bus.id_addr,  data: bus.id_data};

    // The register file commits the head at every edge where something is queued.
    assign pop = (count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push0    (alu_acc),
        .entry0   (alu_entry),
        .push1    (id_acc),
        .entry1   (id_entry),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .head_ptr (head_ptr),
        .entries  (entries)
    );

    // Write port is a gated view of the head; an empty queue drives all zeros.
    assign bus.w_enable = pop;
    assign bus.w_addr   = pop ? head.addr : '0;
    assign bus.w_select = pop ? head.sel  : 1'b0;
    assign bus.w_alu    = (pop && head.sel == SEL_ALU) ? head.data : '0;
    assign bus.w_id     = (pop && head.sel == SEL_ID)  ? head.data : '0;

`ifdef RF_WB_BYPASS_EN
    logic [PTR_W-1:0]     idx;
    logic                 hit_0;
    logic                 hit_1;
    logic [RF_DATA_W-1:0] data_0;
    logic [RF_DATA_W-1:0] data_1;

    // Walk live entries oldest to youngest so the youngest match overwrites older ones.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        idx    = '0;
        hit_0  = 1'b0;
        hit_1  = 1'b0;
        data_0 = '0;
        data_1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (entries[idx].addr == bus.rd_addr_0) begin
                    hit_0  = 1'b1;
                    data_0 = entries[idx].data;
                end
                if (entries[idx].addr == bus.rd_addr_1) begin
                    hit_1  = 1'b1;
                    data_1 = entries[idx].data;
                end
            end
        end
    end

    assign bus.byp_hit_0  = hit_0;
    assign bus.byp_hit_1  = hit_1;
    assign bus.byp_data_0 = data_0;
    assign bus.byp_data_1 = data_1;
`else
    assign bus.byp_hit_0  = 1'b0;
    assign bus.byp_hit_1  = 1'b0;
    assign bus.byp_data_0 = '0;
    assign bus.byp_data_1 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized self-checking bench for regfile_wb_ctrl. A queue-based model of
// pending writes predicts readiness, the write port and bypass results, and
// a model register file is compared with the writes seen on the port.
module tb_regfile_wb_ctrl;
    import regfile_wb_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;

    regfile_wb_ctrl_if bus ();

    regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    wb_entry_t   mq[$];
    logic [31:0] model_rf[8];
    logic [31:0] seen_rf[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic drive_idle();
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.id_valid  = 1'b0; bus.id_addr  = '0; bus.id_data  = '0;
        bus.rd_addr_0 = '0;   bus.rd_addr_1 = '0;
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model, wait a cycle.
    task automatic cycle(input logic av, input logic [2:0] aa, input logic [31:0] ad,
                         input logic iv, input logic [2:0] ia, input logic [31:0] id,
                         input logic [2:0] r0, input logic [2:0] r1);
        logic        exp_ar, exp_ir, eh0, eh1;
        logic [31:0] ed0, ed1;
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.id_valid  = iv; bus.id_addr  = ia; bus.id_data  = id;
        bus.rd_addr_0 = r0; bus.rd_addr_1 = r1;
        #1;
        exp_ar = (mq.size() <= DEPTH - 1);
        exp_ir = av ? (mq.size() <= DEPTH - 2) : (mq.size() <= DEPTH - 1);
        check("alu_ready", bus.alu_ready, exp_ar);
        check("id_ready",  bus.id_ready,  exp_ir);
        if (mq.size() == 0) begin
            check("w_enable", bus.w_enable, 0);
            check("w_addr",   bus.w_addr,   0);
            check("w_select", bus.w_select, 0);
            check("w_alu",    bus.w_alu,    0);
            check("w_id",     bus.w_id,     0);
        end else begin
            check("w_enable", bus.w_enable, 1);
            check("w_addr",   bus.w_addr,   mq[0].addr);
            check("w_select", bus.w_select, mq[0].sel);
            check("w_alu",    bus.w_alu,    mq[0].sel ? 32'h0 : mq[0].data);
            check("w_id",     bus.w_id,     mq[0].sel ? mq[0].data : 32'h0);
        end
        eh0 = 1'b0; eh1 = 1'b0; ed0 = '0; ed1 = '0;
`ifdef RF_WB_BYPASS_EN
        foreach (mq[i]) begin
            if (mq[i].addr == r0) begin eh0 = 1'b1; ed0 = mq[i].data; end
            if (mq[i].addr == r1) begin eh1 = 1'b1; ed1 = mq[i].data; end
        end
`endif
        check("byp_hit_0",  bus.byp_hit_0,  eh0);
        check("byp_data_0", bus.byp_data_0, ed0);
        check("byp_hit_1",  bus.byp_hit_1,  eh1);
        check("byp_data_1", bus.byp_data_1, ed1);
        if (bus.w_enable) seen_rf[bus.w_addr] = bus.w_select ? bus.w_id : bus.w_alu;
        if (mq.size() != 0) begin
            model_rf[mq[0].addr] = mq[0].data;
            void'(mq.pop_front());
        end
        if (av && exp_ar) mq.push_back('{sel: SEL_ALU, addr: aa, data: ad});
        if (iv && exp_ir) mq.push_back('{sel: SEL_ID,  addr: ia, data: id});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int r = 0; r < 8; r++) begin model_rf[r] = '0; seen_rf[r] = '0; end
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        idle(1);

        // Single ALU write into an empty queue.
        cycle(1, 3'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        idle(2);

        // Same-address ALU then ID in one cycle; the ID value must win.
        cycle(1, 3'd2, 32'h11, 1, 3'd2, 32'h22, 3'd2, 3'd0);
        idle(3);
        check("r2_last_wins", seen_rf[2], 32'h22);

        // Both sources valid every cycle: readiness throttling and ordering.
        for (int k = 0; k < 6; k++)
            cycle(1, 3'($urandom_range(0, 7)), $urandom,
                  1, 3'($urandom_range(0, 7)), $urandom, 3'(k), 3'(7 - k));
        idle(5);

        // Two queued writes to r3; lookups on r3 and r7.
        cycle(1, 3'd3, 32'h5, 1, 3'd3, 32'h9, 3'd3, 3'd7);
        cycle(0, 0, 0, 0, 0, 0, 3'd3, 3'd7);
        cycle(0, 0, 0, 0, 0, 0, 3'd3, 3'd7);
        idle(2);

        // Random traffic with random lookups.
        for (int k = 0; k < 300; k++)
            cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        idle(5);

        for (int r = 0; r < 8; r++) check($sformatf("rf_r%0d", r), seen_rf[r], model_rf[r]);

        // Build up three pending writes, then reset asynchronously mid-cycle.
        cycle(1, 3'd1, 32'hA1, 1, 3'd4, 32'hB4, 0, 0);
        cycle(1, 3'd6, 32'hC6, 1, 3'd0, 32'hD0, 0, 0);
        check("pre_reset_depth", mq.size(), 3);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_w_enable",  bus.w_enable,  0);
        check("rst_w_alu",     bus.w_alu,     0);
        check("rst_w_id",      bus.w_id,      0);
        check("rst_alu_ready", bus.alu_ready, 1);
        check("rst_id_ready",  bus.id_ready,  1);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Traffic after reset release.
        cycle(1, 3'd7, 32'h1234_5678, 0, 0, 0, 3'd7, 3'd1);
        idle(2);
        check("post_reset_r7", seen_rf[7], 32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller that drives the single write port of the 8×32 register file, acting as the producer side of that port's `w_addr`/`w_enable`/`w_select`/`w_alu`/`w_id` interface. It accepts results from the ALU stage and the ID stage over valid/ready handshakes and queues them in program order. It retires at most one write per cycle, resolving same-cycle collisions that the single-ported file cannot absorb. An optional bypass lookup lets operand readers see queued-but-uncommitted values.

## Interface
- `DEPTH`, 4, queue entries (power of two, ≥2)
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `alu_valid`  in  1  ALU result offered
- `alu_addr`  in  3  ALU destination register
- `alu_data`  in  32  ALU result
- `alu_ready`  out  1  ALU result accepted when `alu_valid & alu_ready`
- `id_valid`  in  1  ID-stage result offered
- `id_addr`  in  3  ID destination register
- `id_data`  in  32  ID result
- `id_ready`  out  1  ID result accepted when `id_valid & id_ready`
- `w_addr`  out  3  register file write address
- `w_enable`  out  1  register file write enable
- `w_select`  out  1  0 = ALU data, 1 = ID data
- `w_alu`  out  32  write data, ALU path
- `w_id`  out  32  write data, ID path
- `rd_addr_0`, `rd_addr_1`  in  3  bypass lookup addresses
- `byp_hit_0`, `byp_hit_1`  out  1  queued write pending for the lookup address
- `byp_data_0`, `byp_data_1`  out  32  youngest queued data for the lookup address

## Operation
- Queue entry is {sel, addr[2:0], data[31:0]}.
- Circular buffer with head/tail pointers and a `count` of 0..DEPTH.
- Enqueue order within a cycle: ALU entry first, then ID entry. ALU is the older instruction.
- `alu_ready` = `count ≤ DEPTH-1`.
- `id_ready` = `count ≤ DEPTH-2` when `alu_valid`, else `count ≤ DEPTH-1`.
- No pop credit: ready is derived from the registered `count` only.
- Write port outputs are combinational from the head entry:
  - `w_enable` = `count != 0`
  - `w_addr` = head.addr
  - `w_select` = head.sel
  - `w_alu` = head.data if sel=0, else 0
  - `w_id` = head.data if sel=1, else 0
- When `count = 0`, all write port outputs are 0.
- Dequeue occurs every cycle with `count != 0`; the register file commits at that edge.
- `count_next` = `count` + accepted(0..2) − pop(0/1). Pointers wrap modulo DEPTH.
- Back-to-back writes to the same address commit in order, so the last one wins.

## Timing
- Reset: `count`=0, pointers=0. All outputs 0 except `alu_ready`=1 and `id_ready`=1. Queue contents don't care.
- Latency: an entry accepted at edge N is presented on the write port during cycle N+1 if the queue was empty, and is committed at edge N+1.
- Throughput: 1 write/cycle sustained; bursts of 2/cycle are absorbed up to DEPTH.
- Full (`count = DEPTH`): both readies 0. The head still retires, so ready returns the next cycle.
- Reset asserted mid-operation: queue flushed and `w_enable` drops immediately (asynchronous). Pending writes are discarded by design.
- Simultaneous accept and pop at `count = DEPTH-1`: the ALU entry is accepted and `count` stays DEPTH-1.

## Configuration
- `RF_WB_BYPASS_EN` defined:
  - `byp_hit_k` = any valid queue entry with addr == `rd_addr_k`. The head counts, since it is not yet committed this cycle.
  - `byp_data_k` = data of the youngest matching entry.
  - Combinational, no added latency.
- Not defined: lookup inputs ignored, `byp_hit_k`=0, `byp_data_k`=0, and the compare logic is absent.

## Structure
- `regfile_wb_pkg`:
  - `wb_entry_t` struct
  - `SEL_ALU`=1'b0, `SEL_ID`=1'b1
  - `RF_ADDR_W`=3, `RF_DATA_W`=32
- Sub-module `wb_fifo`: dual-push, single-pop circular buffer exposing head, count and the entry array for bypass search. `regfile_wb_ctrl` holds the ready logic, output muxing and bypass.

## Test plan
- Reset with queue holding 3 entries → `w_enable`=0 at once, `count`=0, both readies 1 after release.
- Single ALU write of addr 5 with 0xDEADBEEF into an empty queue → next cycle `w_enable`=1, `w_addr`=5, `w_select`=0, `w_alu`=0xDEADBEEF, `w_id`=0.
- ALU addr 2 = 0x11 and ID addr 2 = 0x22 in the same cycle → two consecutive writes, ALU first then ID; a model register file ends with r2 = 0x22.
- Both sources valid every cycle for 6 cycles with DEPTH=4 → `id_ready` drops when `count`≥3 and `alu_ready` drops at `count`=4. No entry is lost or reordered, and all accepted writes commit in order.
- Bypass build: queue holds r3=0x5, then r3=0x9, with `rd_addr_0`=3 → `byp_hit_0`=1, `byp_data_0`=0x9. With `rd_addr_1`=7 → `byp_hit_1`=0.
- Build without `RF_WB_BYPASS_EN`, same stimulus → `byp_hit_k`=0 and `byp_data_k`=0 throughout.
